mem_stall_responder: RTL

//   Responder (memory-side) end of the processor's stalling data-memory interface.

---
 rtl/mem_resp_pkg.sv | 23 ++
 rtl/mem_resp_array.sv | 24 ++
 rtl/mem_stall_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the stalling memory responder: FSM encoding,
// word width, counter width and the LFSR used for optional random stall stretching.
package mem_resp_pkg;

  localparam int WORD_W = 16;
  // Wide enough for LATENCY (max 15) plus up to 3 random extra cycles.
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Fibonacci taps 8,6,5,4 map to bit indices 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word RAM for the responder: synchronous write, asynchronous read, no reset
// so contents survive rst.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stall_responder.sv
// Memory-side responder for the processor's stalling data interface.
// Define RAND_STALL_EN to stretch each access by 0..3 LFSR-chosen cycles.
module mem_stall_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is Rd xor Wr held high in IDLE; it is accepted in the
  // same cycle (Stall rises combinationally). Inputs are ignored until the
  // one-cycle Done pulse, after which a new request may be presented.

  localparam int WA_W = ADDR_W - 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  extra;
  logic [CNT_W-1:0]  lat_total;
  logic              legal;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^Addr[15:ADDR_W];

`ifdef RAND_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);
  assign extra  = CNT_W'(lfsr_q[1:0]);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign extra = '0;
`endif

  assign legal     = (Rd ^ Wr) & ~Addr[0];
  assign lat_total = CNT_W'(LATENCY) + extra;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Rd | Wr) begin
          if (legal) begin
            waddr_d = Addr[ADDR_W-1:1];
            wdata_d = DataIn;
            op_wr_d = Wr;
            if (lat_total == CNT_W'(1)) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              state_d = BUSY;
              cnt_d   = lat_total - CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // The cycle that brings the counter to zero is the last stall cycle.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst keeps an aborted write out of the array.
  assign Done      = (state_q == DONE) & ~rst;
  assign mem_we    = Done & op_wr_q;
  assign DataOut   = (Done & ~op_wr_q) ? mem_rdata : '0;
  assign Stall     = (state_q == BUSY) | ((state_q == IDLE) & legal);
  assign err       = err_q;
  assign dbg_state = state_q;

  mem_resp_array #(
    .DEPTH(2 ** WA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (waddr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule
